// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side endpoint of the shared memory request bus. Every request
//   strobe is pushed into an in-order request queue; a small service FSM
//   pops one request per cycle, executes it against an internal 64-bit
//   word array and launches it down a fixed delay pipeline. Exactly one
//   mem_valid pulse is returned per accepted request, in request order.
//   Periodic refresh windows stop popping while accepts continue, so the
//   queue absorbs the stall.
//
// Ports
//   clk           clock
//   rst           synchronous, active-high reset (queue, pipeline, refresh
//                 state and sticky flags; the word array is preserved)
//   mem_req       request strobe, sampled every edge
//   mem_we        1 = write, 0 = read
//   mem_addr      byte address; word index = mem_addr[ADDR_W+2:3]
//   mem_wdata     write data
//   mem_valid     single-cycle response pulse
//   mem_rdata     read data while mem_valid=1, otherwise 0 (0 for write acks)
//   busy          queue or service pipeline non-empty
//   err_overflow  sticky: a request was dropped because the queue was full
//   err_oob       sticky: a request addressed beyond the array
module mem_responder #(
   parameter int ADDR_W         = 10,
   parameter int LATENCY        = 4,
   parameter int QDEPTH         = 16,
   parameter int REFRESH_PERIOD = 256,
   parameter int REFRESH_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [63:0] mem_addr,
   input  logic [63:0] mem_wdata,
   output logic        mem_valid,
   output logic [63:0] mem_rdata,
   output logic        busy,
   output logic        err_overflow,
   output logic        err_oob
);

   localparam int QAW    = $clog2(QDEPTH);
   // Stage 0 is loaded on the pop edge, one edge after the request edge,
   // so LATENCY-1 further stages put the pulse exactly LATENCY edges out.
   localparam int STAGES = LATENCY - 1;
   localparam int RW     = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
   localparam int CW     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam bit REF_EN = (REFRESH_PERIOD > 0) && (REFRESH_CYCLES > 0);
   localparam logic [RW-1:0] REF_LAST =
      (REFRESH_PERIOD > 0) ? RW'(REFRESH_PERIOD - 1) : '0;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] idx;
      logic              oob;
      logic [63:0]       wdata;
   } req_t;

   typedef enum logic {RUN, REFRESH} state_t;

   // ------------------------------------------------------------------
   // Request queue
   // ------------------------------------------------------------------
   req_t           q [QDEPTH];
   logic [QAW:0]   wr_ptr, rd_ptr;
   logic           empty, full;
   logic           push, pop;
   req_t           new_req, head;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[QAW] != rd_ptr[QAW]) &&
                  (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);
   assign head  = q[rd_ptr[QAW-1:0]];

   assign new_req.we    = mem_we;
   assign new_req.idx   = mem_addr[ADDR_W+2:3];
   assign new_req.oob   = |mem_addr[63:ADDR_W+3];
   assign new_req.wdata = mem_wdata;

   // Byte offset within the word has no meaning for a word-wide array.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^mem_addr[2:0];

   // A full queue still accepts when the head leaves in the same cycle.
   assign push = mem_req && (!full || pop);

   always_ff @(posedge clk) begin
      if (push) q[wr_ptr[QAW-1:0]] <= new_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Refresh timing and service FSM
   // ------------------------------------------------------------------
   state_t         state;
   logic [RW-1:0]  ref_cnt;
   logic [CW-1:0]  ref_left;
   logic           ref_hit;

   assign ref_hit = REF_EN && (ref_cnt == REF_LAST);

   // The refresh entry edge itself is the first stalled cycle; a head that
   // is waiting there stays queued until the window closes.
   assign pop = (state == RUN) && !ref_hit && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         ref_cnt  <= '0;
         ref_left <= '0;
      end else begin
         // Free-running; restarts on each refresh entry.
         if (ref_hit) ref_cnt <= '0;
         else         ref_cnt <= ref_cnt + 1'b1;

         case (state)
            RUN: begin
               // A one-cycle window is fully covered by the entry edge.
               if (ref_hit && (REFRESH_CYCLES > 1)) begin
                  state    <= REFRESH;
                  ref_left <= CW'(REFRESH_CYCLES - 1);
               end
            end
            REFRESH: begin
               ref_left <= ref_left - 1'b1;
               if (ref_left == CW'(1)) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Word array: written and read only in the service (pop) cycle, so a
   // read issued in any cycle after a write always sees the new data.
   // ------------------------------------------------------------------
   logic [63:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (pop && head.we && !head.oob) mem[head.idx] <= head.wdata;
   end

   // ------------------------------------------------------------------
   // Delay pipeline. Data travels as 0 on bubbles and write acks so the
   // output register already carries the "0 unless valid" rule.
   // ------------------------------------------------------------------
   logic [STAGES:0]       vld_pipe;
   logic [STAGES:0][63:0] data_pipe;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe  <= '0;
         data_pipe <= '0;
      end else begin
         vld_pipe[0]  <= pop;
         data_pipe[0] <= (pop && !head.we && !head.oob) ? mem[head.idx] : '0;
         for (int s = 1; s <= STAGES; s++) begin
            vld_pipe[s]  <= vld_pipe[s-1];
            data_pipe[s] <= data_pipe[s-1];
         end
      end
   end

   assign mem_valid = vld_pipe[STAGES];
   assign mem_rdata = data_pipe[STAGES];
   assign busy      = !empty || (|vld_pipe);

   // ------------------------------------------------------------------
   // Sticky error flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         err_overflow <= 1'b0;
         err_oob      <= 1'b0;
      end else begin
         if (mem_req && full && !pop) err_overflow <= 1'b1;
         if (mem_req && new_req.oob)  err_oob      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Three instances share the request bus
// fields and the reset but have private request strobes:
//   u_a  default parameters, refresh disabled
//   u_b  REFRESH_PERIOD=32, REFRESH_CYCLES=4
//   u_c  QDEPTH=4, REFRESH_PERIOD=64, REFRESH_CYCLES=16
// Responses are logged with the edge number at which mem_valid rose.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_a, req_b, req_c;
   logic        we;
   logic [63:0] addr, wdata;

   logic        v_a, v_b, v_c;
   logic [63:0] rd_a, rd_b, rd_c;
   logic        busy_a, busy_b, busy_c;
   logic        ovf_a, ovf_b, ovf_c;
   logic        oob_a, oob_b, oob_c;

   mem_responder #(.REFRESH_PERIOD(0)) u_a (
      .clk(clk), .rst(rst), .mem_req(req_a), .mem_we(we), .mem_addr(addr),
      .mem_wdata(wdata), .mem_valid(v_a), .mem_rdata(rd_a), .busy(busy_a),
      .err_overflow(ovf_a), .err_oob(oob_a));

   mem_responder #(.REFRESH_PERIOD(32), .REFRESH_CYCLES(4)) u_b (
      .clk(clk), .rst(rst), .mem_req(req_b), .mem_we(we), .mem_addr(addr),
      .mem_wdata(wdata), .mem_valid(v_b), .mem_rdata(rd_b), .busy(busy_b),
      .err_overflow(ovf_b), .err_oob(oob_b));

   mem_responder #(.QDEPTH(4), .REFRESH_PERIOD(64), .REFRESH_CYCLES(16)) u_c (
      .clk(clk), .rst(rst), .mem_req(req_c), .mem_we(we), .mem_addr(addr),
      .mem_wdata(wdata), .mem_valid(v_c), .mem_rdata(rd_c), .busy(busy_c),
      .err_overflow(ovf_c), .err_oob(oob_c));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          t_a[$], t_b[$], t_c[$];
   logic [63:0] d_a[$], d_b[$], d_c[$];

   always @(negedge clk) begin
      if (v_a) begin t_a.push_back(cyc); d_a.push_back(rd_a); end
      if (v_b) begin t_b.push_back(cyc); d_b.push_back(rd_b); end
      if (v_c) begin t_c.push_back(cyc); d_c.push_back(rd_c); end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one request, sampled at the next edge; sel picks {c,b,a}.
   task automatic send(input logic [2:0] sel, input logic w,
                       input logic [63:0] a, input logic [63:0] d);
      we    = w;
      addr  = a;
      wdata = d;
      req_a = sel[0];
      req_b = sel[1];
      req_c = sel[2];
      step();
      req_a = 1'b0;
      req_b = 1'b0;
      req_c = 1'b0;
   endtask

   // Return so that the next driven request is sampled at edge t.
   task automatic go_to(input int t);
      while (cyc < t - 1) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int r0, e, ngap;

   initial begin
      rst = 1'b1;
      req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
      we = 1'b0; addr = '0; wdata = '0;
      repeat (3) step();
      rst = 1'b0;
      r0 = cyc;   // last edge with rst=1; refresh counters read 0 after it

      check("rst_valid", v_a, 0);
      check("rst_rdata", rd_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_oob", oob_a, 0);
      check("rst_busy_c", busy_c, 0);

      // Preload: B words 0..39 and C words 0..9 with 1000+i (edges r0+1..r0+40).
      for (int i = 0; i < 40; i++)
         send((i < 10) ? 3'b110 : 3'b010, 1'b1, 64'(i * 8), 64'(1000 + i));

      // ---- Refresh stall on B: reads at r0+100..r0+139, refresh entry r0+128
      go_to(r0 + 100);
      check("b_wr_acks", t_b.size(), 40);
      check("c_wr_acks", t_c.size(), 10);
      t_b.delete(); d_b.delete(); t_c.delete(); d_c.delete();
      e = cyc + 1;
      for (int i = 0; i < 40; i++) send(3'b010, 1'b0, 64'(i * 8), '0);
      repeat (30) step();
      check("b_count", t_b.size(), 40);
      for (int i = 0; i < t_b.size() && i < 40; i++)
         check($sformatf("b_data%0d", i), d_b[i], 64'(1000 + i));
      if (t_b.size() > 0) check("b_first_lat", t_b[0] - e, 4);
      ngap = 0;
      for (int i = 1; i < t_b.size(); i++)
         if (t_b[i] - t_b[i-1] != 1) ngap++;
      check("b_ngaps", ngap, 1);
      if (t_b.size() == 40) check("b_gap_len", t_b[27] - t_b[26], 5);
      check("b_ovf", ovf_b, 0);
      check("b_busy", busy_b, 0);

      // ---- Overflow on C: 10 reads at refresh start r0+192; only 4 fit
      go_to(r0 + 192);
      check("c_ovf_pre", ovf_c, 0);
      for (int i = 0; i < 10; i++) send(3'b100, 1'b0, 64'(i * 8), '0);
      repeat (30) step();
      check("c_count", t_c.size(), 4);
      for (int i = 0; i < t_c.size() && i < 4; i++)
         check($sformatf("c_data%0d", i), d_c[i], 64'(1000 + i));
      if (t_c.size() > 0) check("c_first_edge", t_c[0] - r0, 211);
      check("c_ovf", ovf_c, 1);
      check("c_busy", busy_c, 0);

      // ---- A: write then read of 0x18
      e = cyc + 1;
      send(3'b001, 1'b1, 64'h18, 64'hDEADBEEF);
      send(3'b001, 1'b0, 64'h18, '0);
      repeat (8) step();
      check("a_rw_count", t_a.size(), 2);
      if (t_a.size() == 2) begin
         check("a_wr_lat", t_a[0] - e, 4);
         check("a_wr_data", d_a[0], 0);
         check("a_rd_lat", t_a[1] - e, 5);
         check("a_rd_data", d_a[1], 64'hDEADBEEF);
      end
      check("a_busy_idle", busy_a, 0);

      // ---- A: preload words 0..7 = 100..107, then 8 back-to-back reads
      for (int i = 0; i < 8; i++) send(3'b001, 1'b1, 64'(i * 8), 64'(100 + i));
      repeat (8) step();
      check("a_pre_acks", t_a.size(), 10);
      t_a.delete(); d_a.delete();
      e = cyc + 1;
      for (int i = 0; i < 8; i++) send(3'b001, 1'b0, 64'(i * 8), '0);
      repeat (12) step();
      check("a_b2b_count", t_a.size(), 8);
      for (int i = 0; i < t_a.size() && i < 8; i++) begin
         check($sformatf("a_b2b_edge%0d", i), t_a[i] - e, 64'(4 + i));
         check($sformatf("a_b2b_data%0d", i), d_a[i], 64'(100 + i));
      end

      // ---- A: out-of-range write/read at 0x8000 (word index 0)
      check("a_oob_pre", oob_a, 0);
      t_a.delete(); d_a.delete();
      e = cyc + 1;
      send(3'b001, 1'b1, 64'h8000, 64'h1234);
      send(3'b001, 1'b0, 64'h8000, '0);
      send(3'b001, 1'b0, 64'h0, '0);
      repeat (10) step();
      check("a_oob_count", t_a.size(), 3);
      if (t_a.size() == 3) begin
         check("a_oob_wr_data", d_a[0], 0);
         check("a_oob_rd_lat", t_a[1] - e, 5);
         check("a_oob_rd_data", d_a[1], 0);
         check("a_word0_kept", d_a[2], 100);
      end
      check("a_oob_flag", oob_a, 1);
      check("a_ovf", ovf_a, 0);

      // ---- A: reset with three reads in flight
      t_a.delete(); d_a.delete();
      for (int i = 0; i < 3; i++) send(3'b001, 1'b0, 64'h8, '0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rr_busy", busy_a, 0);
      check("rr_valid", v_a, 0);
      check("rr_rdata", rd_a, 0);
      check("rr_oob", oob_a, 0);
      check("rr_ovf_c", ovf_c, 0);
      repeat (10) step();
      check("rr_no_resp", t_a.size(), 0);
      e = cyc + 1;
      send(3'b001, 1'b0, 64'h8, '0);
      repeat (8) step();
      check("rr_post_count", t_a.size(), 1);
      if (t_a.size() == 1) begin
         check("rr_post_lat", t_a[0] - e, 4);
         check("rr_post_data", d_a[0], 101);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side endpoint of the shared memory request bus driven by the memory arbiter.
- Accepts one request per cycle with no backpressure, buffers it in a request queue, and serves it against an internal word-addressed 64-bit array.
- Returns exactly one mem_valid pulse per accepted request, reads and writes alike, strictly in request order, as the arbiter's ticket routing requires.
- Models periodic refresh stalls that are absorbed by the queue. Used as the memory model and as the controller front end.

Parameters:
- ADDR_W, 10, word-index bits; the array holds 2^ADDR_W 64-bit words.
- LATENCY, 4, cycles from the request edge to mem_valid when the queue is idle and no refresh is active; minimum 2.
- QDEPTH, 16, request queue entries; power of 2.
- REFRESH_PERIOD, 256, cycles between refresh windows; 0 disables refresh.
- REFRESH_CYCLES, 4, length of each refresh window in cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_req  in  1  request strobe; sampled every edge
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  64  byte address; word index = mem_addr[ADDR_W+2:3]
- mem_wdata  in  64  write data
- mem_valid  out  1  single-cycle response pulse
- mem_rdata  out  64  read data; 0 for write acks
- busy  out  1  queue or service pipeline non-empty
- err_overflow  out  1  sticky; a request was dropped on a full queue
- err_oob  out  1  sticky; a request addressed beyond the array

Behaviour:
- Reset:
  - Clock is clk; reset is rst, synchronous, active-high.
  - Reset clears the queue, the service pipeline, the refresh counter and the refresh state.
  - Outputs after reset: mem_valid=0, mem_rdata=0, busy=0, err_overflow=0, err_oob=0.
  - In-flight requests are discarded with no response.
  - Array contents are not cleared by rst; the simulation initial value is 0.
- Accept:
  - Every edge with mem_req=1 pushes {we, word index, oob bit, wdata} into the queue.
  - When the queue is full and no pop happens that cycle, the request is dropped and err_overflow is set. This is fatal to the arbiter, so no response is generated for the dropped request.
  - Full queue with a pop in the same cycle: the push is accepted.
- Service FSM, states RUN and REFRESH:
  - RUN: each cycle with a non-empty queue pops the head and executes it.
    - Write: the array is updated in the service cycle.
    - Read: the array is read in the service cycle.
  - Each executed request enters a fixed-depth delay pipeline sized so that idle-path latency equals LATENCY exactly.
  - Throughput is one response per cycle; back-to-back mem_valid pulses are allowed.
- Ordering:
  - Strict FIFO order.
  - A read issued after a write to the same word, in any later cycle, returns the written data.
- Out-of-range addresses:
  - A request is out of range if any mem_addr bit above ADDR_W+2 is set.
  - Write: ignored. Read: returns 0. Either way it is still acknowledged and err_oob is set.
- mem_addr[2:0] is ignored.
- Refresh (REFRESH_PERIOD>0):
  - A free-running counter increments every cycle.
  - At count REFRESH_PERIOD-1 the FSM enters REFRESH for REFRESH_CYCLES cycles and the counter restarts at 0.
  - In REFRESH there are no pops; accepts continue; the pipeline keeps draining.
  - Return to RUN afterwards.
  - Refresh entry preempts a queued head; a request already popped completes normally.
- Response: mem_valid is high for one cycle per executed request. mem_rdata is valid only while mem_valid=1 and is 0 otherwise.
- busy = queue non-empty OR any pipeline stage occupied.
- Sticky flags clear only on rst.

Test Plan:
- LATENCY=4, refresh disabled: write at edge 10 (addr 0x18, data 0xDEADBEEF) -> mem_valid at edge 14 with rdata=0. Read of 0x18 at edge 11 -> mem_valid at edge 15 with rdata=0xDEADBEEF.
- 8 back-to-back reads at edges 20..27 of words preloaded 0..7 with values 100..107 -> mem_valid high at edges 24..31, rdata 100..107 in order.
- REFRESH_PERIOD=32, REFRESH_CYCLES=4, continuous reads for 40 cycles -> exactly one 4-cycle mem_valid gap after the refresh entry, 40 responses total, order preserved, err_overflow=0.
- QDEPTH=4, REFRESH_CYCLES=16, 10 requests issued at refresh start -> err_overflow=1 and exactly the accepted requests are acknowledged, in order.
- Read at mem_addr=0x8000 with ADDR_W=10 -> mem_valid after LATENCY cycles, rdata=0, err_oob=1. A prior write to the same address leaves the array unchanged.
- rst asserted with 3 requests in flight -> no mem_valid afterwards, busy=0 on the next cycle, flags 0. A post-reset read of a word written before the reset returns the written value.
